hetszegmens_n: RTL and testbench

Parametrised, time-multiplexed seven-segment display driver for N digits, the successor of the two-digit `hetszegmens` driver. Each digit has its own hex nibble and decimal point. A double-buffered load keeps the display from tearing mid-frame. The block also provides optional leading-zero suppression, PWM brightness control, and a frame-start pulse. It sits between the calculator datapath and the board's common-anode display pins.

---
 rtl/hetszegmens_n.sv | 207 ++++++++++++++++++++
 tb/tb_hetszegmens_n.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/hetszegmens_n.sv
// hetszegmens_n -- time-multiplexed seven-segment driver for DIGITS digits.
//
// Drives a common-anode display one digit per slot of DIV clocks. New
// digit data is captured into a shadow buffer on load. It is copied to the
// active buffer only at the frame boundary, so a frame never mixes old and
// new data. Optional features:
//   - leading-zero blanking
//   - PWM brightness within each slot
//   - a one-cycle frame-start pulse
//
// Ports
//   clk     system clock
//   rst     synchronous active-high reset
//   din     hex nibbles, din[4i+3:4i] is digit i (digit 0 rightmost)
//   dp      decimal point request per digit, 1 = lit
//   load    one-cycle strobe capturing din/dp into the shadow buffer
//   lz_en   leading-zero suppression enable (live)
//   bright  brightness, 0 = dimmest, all ones = full (live)
//   AN      digit anodes, active low, registered
//   SEG     segments {dp,g,f,e,d,c,b,a}, active low, registered
//   frame   one-cycle pulse in the first cycle of each frame, registered

module hetszegmens_n #(
   parameter int DIGITS   = 4,
   parameter int DIV      = 1000,
   parameter int BRIGHT_W = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*DIGITS-1:0]   din,
   input  logic [DIGITS-1:0]     dp,
   input  logic                  load,
   input  logic                  lz_en,
   input  logic [BRIGHT_W-1:0]   bright,
   output logic [DIGITS-1:0]     AN,
   output logic [7:0]            SEG,
   output logic                  frame
);

   localparam int CNT_W = $clog2(DIV);
   localparam int IDX_W = $clog2(DIGITS);
   // Wide enough to hold (2^BRIGHT_W) * DIV without overflow.
   localparam int ON_W  = CNT_W + BRIGHT_W + 1;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

   // Active-low a..g pattern for one hex nibble.
   function automatic logic [6:0] hex7(input logic [3:0] nib);
      logic [6:0] pat;
      case (nib)
         4'h0:    pat = 7'h40;
         4'h1:    pat = 7'h79;
         4'h2:    pat = 7'h24;
         4'h3:    pat = 7'h30;
         4'h4:    pat = 7'h19;
         4'h5:    pat = 7'h12;
         4'h6:    pat = 7'h02;
         4'h7:    pat = 7'h78;
         4'h8:    pat = 7'h00;
         4'h9:    pat = 7'h10;
         4'hA:    pat = 7'h08;
         4'hB:    pat = 7'h03;
         4'hC:    pat = 7'h46;
         4'hD:    pat = 7'h21;
         4'hE:    pat = 7'h06;
         4'hF:    pat = 7'h0E;
         default: pat = 7'h7F;
      endcase
      return pat;
   endfunction

   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [4*DIGITS-1:0] shd_din_q, shd_din_d, act_din_q, act_din_d;
   logic [DIGITS-1:0]   shd_dp_q, shd_dp_d, act_dp_q, act_dp_d;
   logic                pending_q, pending_d;
   logic [DIGITS-1:0]   an_q, an_d;
   logic [7:0]          seg_q, seg_d;
   logic                frame_q, frame_d;

   logic                slot_end_s, frame_end_s, commit_s;
   logic [3:0]          nib_s;
   logic                dig_dp_s, blank_s, zero_above_s, pwm_on_s;
   logic [ON_W-1:0]     on_time_s;

   // Slot timing, load/commit double buffering and frame pulse next state.
   always_comb begin
      slot_end_s  = (cnt_q == CNT_LAST);
      frame_end_s = slot_end_s && (idx_q == IDX_LAST);
      commit_s    = frame_end_s && pending_q;

      if (slot_end_s) begin
         cnt_d = {CNT_W{1'b0}};
         if (idx_q == IDX_LAST) begin
            idx_d = {IDX_W{1'b0}};
         end else begin
            idx_d = idx_q + IDX_W'(1);
         end
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
         idx_d = idx_q;
      end

      // Commit reads the shadow held before this edge; a coincident load
      // refills the shadow and keeps pending set for the next frame.
      if (commit_s) begin
         act_din_d = shd_din_q;
         act_dp_d  = shd_dp_q;
      end else begin
         act_din_d = act_din_q;
         act_dp_d  = act_dp_q;
      end

      if (load) begin
         shd_din_d = din;
         shd_dp_d  = dp;
         pending_d = 1'b1;
      end else begin
         shd_din_d = shd_din_q;
         shd_dp_d  = shd_dp_q;
         pending_d = pending_q && !commit_s;
      end

      frame_d = frame_end_s;
   end

   // Digit selection, blanking, PWM gating and segment decode.
   always_comb begin
      nib_s        = 4'h0;
      dig_dp_s     = 1'b0;
      blank_s      = 1'b0;
      zero_above_s = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            nib_s    = act_din_q[4*i +: 4];
            dig_dp_s = act_dp_q[i];
         end else begin
            nib_s    = nib_s;
            dig_dp_s = dig_dp_s;
         end
      end
      // Walk from the top digit down; digit 0 is never a candidate.
      for (int i = DIGITS - 1; i >= 1; i--) begin
         zero_above_s = zero_above_s && (act_din_q[4*i +: 4] == 4'h0);
         if (idx_q == IDX_W'(i)) begin
            blank_s = lz_en && zero_above_s;
         end else begin
            blank_s = blank_s;
         end
      end

      on_time_s = ((ON_W'(bright) + ON_W'(1'b1)) * ON_W'(DIV)) >> BRIGHT_W;
      pwm_on_s  = (ON_W'(cnt_q) < on_time_s);

      if (blank_s) begin
         seg_d = {~dig_dp_s, 7'h7F};
      end else begin
         seg_d = {~dig_dp_s, hex7(nib_s)};
      end

      an_d = {DIGITS{1'b1}};
      if (pwm_on_s && (!blank_s || dig_dp_s)) begin
         for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
               an_d[i] = 1'b0;
            end else begin
               an_d[i] = 1'b1;
            end
         end
      end else begin
         an_d = {DIGITS{1'b1}};
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= {CNT_W{1'b0}};
         idx_q     <= {IDX_W{1'b0}};
         shd_din_q <= {(4*DIGITS){1'b0}};
         shd_dp_q  <= {DIGITS{1'b0}};
         act_din_q <= {(4*DIGITS){1'b0}};
         act_dp_q  <= {DIGITS{1'b0}};
         pending_q <= 1'b0;
         an_q      <= {DIGITS{1'b1}};
         seg_q     <= 8'hFF;
         frame_q   <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         shd_din_q <= shd_din_d;
         shd_dp_q  <= shd_dp_d;
         act_din_q <= act_din_d;
         act_dp_q  <= act_dp_d;
         pending_q <= pending_d;
         an_q      <= an_d;
         seg_q     <= seg_d;
         frame_q   <= frame_d;
      end
   end

   assign AN    = an_q;
   assign SEG   = seg_q;
   assign frame = frame_q;

endmodule

// File: tb/tb_hetszegmens_n.sv
// Scoreboard bench for hetszegmens_n (DIGITS=4, DIV=4, BRIGHT_W=2).
// Stimulus pushes expected {AN, SEG, frame} per output cycle into a queue.
// The monitor pops the entry whose cycle stamp matches and compares.

module tb_hetszegmens_n;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] din;
   logic [3:0]  dp;
   logic        load;
   logic        lz_en;
   logic [1:0]  bright;
   logic [3:0]  AN;
   logic [7:0]  SEG;
   logic        frame;

   hetszegmens_n #(.DIGITS(4), .DIV(4), .BRIGHT_W(2)) dut (
      .clk(clk), .rst(rst), .din(din), .dp(dp), .load(load),
      .lz_en(lz_en), .bright(bright), .AN(AN), .SEG(SEG), .frame(frame)
   );

   always #5 clk = ~clk;

   // cyc == k after the k-th rising edge
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      logic [3:0] an;
      logic [7:0] seg;
      logic       chk_seg;
      logic       frm;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   total = 0;
   int   bad   = 0;

   task automatic push(input int c, input logic [3:0] an, input logic [7:0] seg,
                       input logic cs, input logic fr);
      exp_t e;
      e.cyc = c; e.an = an; e.seg = seg; e.chk_seg = cs; e.frm = fr;
      q.push_back(e);
   endtask

   // Expected outputs for one frame whose idx0/cnt0 state begins after edge f.
   // Output at f+1+j shows digit j/4 at slot count j%4; lit only while count < on.
   task automatic exp_frame(input int f, input logic [15:0] an4, input logic [31:0] seg4,
                            input logic [3:0] cs4, input int on, input int nj);
      for (int j = 0; j < nj; j++) begin
         int d;
         int c;
         d = j / 4;
         c = j % 4;
         push(f + 1 + j, (c < on) ? an4[4*d +: 4] : 4'hF, seg4[8*d +: 8], cs4[d], (j == 15));
      end
   endtask

   task automatic wait_cyc(input int k);
      while (cyc < k) @(negedge clk);
   endtask

   // Monitor: compare the entry stamped with the current cycle.
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
         total++;
         bad++;
         $display("FAIL missed_check cyc=%0d expected entry for cyc=%0d", cyc, q[0].cyc);
         void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
         mon_e = q.pop_front();
         total++;
         if (AN !== mon_e.an || (mon_e.chk_seg && SEG !== mon_e.seg) || frame !== mon_e.frm) begin
            bad++;
            $display("FAIL display cyc=%0d AN=%h want %h SEG=%h want %h (checked=%b) frame=%b want %b",
                     cyc, AN, mon_e.an, SEG, mon_e.seg, mon_e.chk_seg, frame, mon_e.frm);
         end
      end
   end

   initial begin
      int guard;
      rst = 1'b1; load = 1'b0; din = 16'h0000; dp = 4'b0000;
      lz_en = 1'b0; bright = 2'd3;

      // 1. reset: dark during reset and on the first released cycle
      for (int c = 1; c <= 10; c++) push(c, 4'hF, 8'hFF, 1'b1, 1'b0);
      exp_frame(10, 16'h7BDE, 32'hC0C0C0C0, 4'hF, 4, 16);
      wait_cyc(10); rst = 1'b0;

      // 2. basic display of 0037
      wait_cyc(12); din = 16'h0037; dp = 4'b0000; load = 1'b1;
      exp_frame(26, 16'h7BDE, 32'hC0C0B0F8, 4'hF, 4, 16);
      wait_cyc(13); load = 1'b0;

      // 3. leading-zero suppression, then zeros with dp on digit 2
      wait_cyc(42); lz_en = 1'b1;
      exp_frame(42, 16'hFFDE, 32'hFFFFB0F8, 4'b0011, 4, 16);
      wait_cyc(44); din = 16'h0000; dp = 4'b0100; load = 1'b1;
      exp_frame(58, 16'hFBFE, 32'hFF7FFFC0, 4'b0101, 4, 16);
      wait_cyc(45); load = 1'b0;

      // 4. brightness 0, 1, 3 (ON = 1, 2, 4 cycles per slot)
      wait_cyc(74); lz_en = 1'b0; bright = 2'd0;
      exp_frame(74, 16'h7BDE, 32'hC040C0C0, 4'hF, 1, 16);
      wait_cyc(90); bright = 2'd1;
      exp_frame(90, 16'h7BDE, 32'hC040C0C0, 4'hF, 2, 16);
      wait_cyc(106); bright = 2'd3;
      exp_frame(106, 16'h7BDE, 32'hC040C0C0, 4'hF, 4, 16);
      exp_frame(122, 16'h7BDE, 32'hC040C0C0, 4'hF, 4, 16);

      // 5. double buffering: two loads mid-frame, last one wins at boundary
      wait_cyc(128); din = 16'h00AF; dp = 4'b0000; load = 1'b1;
      exp_frame(138, 16'h7BDE, 32'hC0C08EF9, 4'hF, 4, 16);
      wait_cyc(129); load = 1'b0;
      wait_cyc(131); din = 16'h00F1; load = 1'b1;
      wait_cyc(132); load = 1'b0;
      // load coincident with commit (edge 154) shows one frame later
      wait_cyc(140); din = 16'h1234; load = 1'b1;
      wait_cyc(141); load = 1'b0;
      wait_cyc(153); din = 16'h5678; load = 1'b1;
      exp_frame(154, 16'h7BDE, 32'hF9A4B099, 4'hF, 4, 16);
      exp_frame(170, 16'h7BDE, 32'h9282F880, 4'hF, 4, 8);
      wait_cyc(154); load = 1'b0;

      // 6. reset while idx=2, with a pending load that must be discarded
      wait_cyc(176); din = 16'h9999; load = 1'b1;
      push(179, 4'hF, 8'hFF, 1'b1, 1'b0);
      exp_frame(179, 16'h7BDE, 32'hC0C0C0C0, 4'hF, 4, 16);
      exp_frame(195, 16'h7BDE, 32'hC0C0C0C0, 4'hF, 4, 16);
      wait_cyc(177); load = 1'b0;
      wait_cyc(178); rst = 1'b1;
      wait_cyc(179); rst = 1'b0;

      guard = 0;
      while (q.size() > 0 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (q.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain timeout: %0d entries left, want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
